// File: rtl/regfile_writeback_pkg.sv
// Shared core constants for the writeback stage: datapath width, register
// address width, load funct3 encodings and the buffered-load entry layout.
package regfile_writeback_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_e;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_load_extend.sv
// Combinational load extractor: picks the addressed byte/half out of the aligned
// memory word and sign- or zero-extends it; LW and unknown types pass through.
module load_extend
    import regfile_writeback_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_data[{i_offset, 3'b000} +: 8];
    assign w_half = i_data[{i_offset[1], 4'b0000} +: 16];

    // NOTE: o_data gets a value on every path (default arm), so no latch is inferred.
    always_comb begin
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results win outright, load responses are
// extended and either bypassed straight through or queued in a small FIFO.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aluValid,
    input  logic [REG_AW-1:0] aluDest,
    input  logic [XLEN-1:0]   aluData,
    input  logic              loadValid,
    output logic              loadReady,
    input  logic [REG_AW-1:0] loadDest,
    input  logic [XLEN-1:0]   loadData,
    input  logic [2:0]        loadFunct3,
    input  logic [1:0]        loadOffset,
    output logic              writeEnable,
    output logic [REG_AW-1:0] dest,
    output logic [XLEN-1:0]   writeData,
    output logic              loadPending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        r_fifo [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic              r_write_enable;
    logic [REG_AW-1:0] r_dest;
    logic [XLEN-1:0]   r_write_data;

    logic [XLEN-1:0] w_ext_data;
    logic            w_accept;
    logic            w_pop;
    logic            w_bypass;
    logic            w_push;
    logic            w_sel_valid;
    wb_entry_t       w_sel;

    load_extend u_load_extend (
        .i_funct3 (loadFunct3),
        .i_offset (loadOffset),
        .i_data   (loadData),
        .o_data   (w_ext_data)
    );

    assign loadReady   = (r_count < CNT_W'(DEPTH)) && !reset;
    assign loadPending = (r_count != '0);

    assign w_accept = loadValid && loadReady;
    assign w_pop    = !aluValid && (r_count != '0);
    // An empty FIFO and an idle ALU let the load skip the queue entirely.
    assign w_bypass = !aluValid && (r_count == '0) && w_accept;
    assign w_push   = w_accept && !w_bypass;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = '0;
        if (aluValid) begin
            w_sel_valid = 1'b1;
            w_sel       = '{dest: aluDest, data: aluData};
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel       = r_fifo[r_rd_ptr];
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel       = '{dest: loadDest, data: w_ext_data};
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{dest: loadDest, data: w_ext_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Writes to x0 still consume the slot and update dest/data, but never strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_enable <= 1'b0;
            r_dest         <= '0;
            r_write_data   <= '0;
        end else begin
            r_write_enable <= w_sel_valid && (w_sel.dest != '0);
            if (w_sel_valid) begin
                r_dest       <= w_sel.dest;
                r_write_data <= w_sel.data;
            end
        end
    end

    assign writeEnable = r_write_enable;
    assign dest        = r_dest;
    assign writeData   = r_write_data;

endmodule
